// File: rtl/linproj_bram_reader_pkg.sv
// Shared types and default tiling for the linear-projection BRAM reader.
// Defaults derive from the projection dimensions of the integrated design.
package linear_proj_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

  localparam int A_OUTER_DIMENSION = 64;
  localparam int B_OUTER_DIMENSION = 64;
  localparam int INNER_DIMENSION   = 12;
  localparam int BLOCK_SIZE        = 4;
  localparam int CHUNK_SIZE        = 4;
  localparam int NUM_CORES_A       = 2;
  localparam int NUM_CORES_B       = 2;
  localparam int TOTAL_INPUT_W     = 4;
  localparam int TOTAL_MODULES     = 4;
  localparam int WIDTH_A           = 8;
  localparam int WIDTH_B           = 8;

  localparam int DEF_ROW_BLOCKS =
    A_OUTER_DIMENSION / (BLOCK_SIZE * NUM_CORES_A * TOTAL_INPUT_W);
  localparam int DEF_COL_BLOCKS =
    B_OUTER_DIMENSION / (BLOCK_SIZE * NUM_CORES_B * TOTAL_MODULES);
  localparam int DEF_INNER_BLOCKS =
    INNER_DIMENSION / CHUNK_SIZE;
  localparam int DEF_DATA_WIDTH_A =
    WIDTH_A * CHUNK_SIZE * NUM_CORES_A;
  localparam int DEF_DATA_WIDTH_B =
    WIDTH_B * CHUNK_SIZE * NUM_CORES_B;

  function automatic int idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/linproj_bram_reader_if.sv
// Control, BRAM read ports and output stream of the BRAM reader.
// The reader takes the master side, its environment the slave side.
interface linproj_bram_reader_if
  import linear_proj_pkg::*;
#(
  parameter int ROW_BLOCKS   = DEF_ROW_BLOCKS,
  parameter int COL_BLOCKS   = DEF_COL_BLOCKS,
  parameter int ADDR_WIDTH_A = 16,
  parameter int ADDR_WIDTH_B = 16,
  parameter int DATA_WIDTH_A = DEF_DATA_WIDTH_A,
  parameter int DATA_WIDTH_B = DEF_DATA_WIDTH_B
) ();

  localparam int RW = idx_w(ROW_BLOCKS);
  localparam int CW = idx_w(COL_BLOCKS);

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    a_en;
  logic [ADDR_WIDTH_A-1:0] a_addr;
  logic [DATA_WIDTH_A-1:0] a_dout;
  logic                    b_en;
  logic [ADDR_WIDTH_B-1:0] b_addr;
  logic [DATA_WIDTH_B-1:0] b_dout;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH_A-1:0] out_a;
  logic [DATA_WIDTH_B-1:0] out_b;
  logic                    out_first;
  logic                    out_last;
  logic [RW-1:0]           out_row_idx;
  logic [CW-1:0]           out_col_idx;

  modport master (
    input  start,
    output busy, done,
    output a_en, a_addr,
    input  a_dout,
    output b_en, b_addr,
    input  b_dout,
    output out_valid,
    input  out_ready,
    output out_a, out_b,
    output out_first, out_last,
    output out_row_idx, out_col_idx
  );

  modport slave (
    output start,
    input  busy, done,
    input  a_en, a_addr,
    output a_dout,
    input  b_en, b_addr,
    output b_dout,
    input  out_valid,
    output out_ready,
    input  out_a, out_b,
    input  out_first, out_last,
    input  out_row_idx, out_col_idx
  );

endinterface

// File: rtl/linproj_bram_reader_tile.sv
// Nested row/column/inner tile counter; k is fastest, r slowest.
// end_o marks the last index triple of a full pass.
module linproj_tile_counter #(
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int INNER = 3,
  parameter int RW    = 2,
  parameter int CW    = 2,
  parameter int KW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [RW-1:0] r_o,
  output logic [CW-1:0] c_o,
  output logic [KW-1:0] k_o,
  output logic          first_o,
  output logic          last_o,
  output logic          end_o
);

  localparam logic [RW-1:0] R_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_MAX = CW'(COLS - 1);
  localparam logic [KW-1:0] K_MAX = KW'(INNER - 1);

  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [KW-1:0] k_q, k_d;

  always_comb begin
    r_d = r_q;
    c_d = c_q;
    k_d = k_q;
    if (clr_i) begin
      r_d = '0;
      c_d = '0;
      k_d = '0;
    end else if (en_i) begin
      if (k_q == K_MAX) begin
        k_d = '0;
        if (c_q == C_MAX) begin
          c_d = '0;
          r_d = (r_q == R_MAX) ? '0 : r_q + RW'(1);
        end else begin
          c_d = c_q + CW'(1);
        end
      end else begin
        k_d = k_q + KW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      c_q <= '0;
      k_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
      k_q <= k_d;
    end
  end

  assign r_o     = r_q;
  assign c_o     = c_q;
  assign k_o     = k_q;
  assign first_o = (k_q == '0);
  assign last_o  = (k_q == K_MAX);
  assign end_o   = last_o && (c_q == C_MAX) && (r_q == R_MAX);

endmodule

// File: rtl/linproj_bram_reader.sv
// Walks input and weight BRAMs in tiled order and streams aligned
// A/B word pairs with first/last markers to the matmul wrapper.
module linproj_bram_reader
  import linear_proj_pkg::*;
#(
  parameter int ROW_BLOCKS   = DEF_ROW_BLOCKS,
  parameter int COL_BLOCKS   = DEF_COL_BLOCKS,
  parameter int INNER_BLOCKS = DEF_INNER_BLOCKS,
  parameter int ADDR_WIDTH_A = 16,
  parameter int ADDR_WIDTH_B = 16,
  parameter int DATA_WIDTH_A = DEF_DATA_WIDTH_A,
  parameter int DATA_WIDTH_B = DEF_DATA_WIDTH_B
) (
  input logic                  clk,
  input logic                  rst,
  linproj_bram_reader_if.master bus
);

  localparam int RW = idx_w(ROW_BLOCKS);
  localparam int CW = idx_w(COL_BLOCKS);
  localparam int KW = idx_w(INNER_BLOCKS);

  state_e state_q, state_d;

  logic          adv;
  logic          issue;
  logic          cnt_clr;
  logic          cnt_end;
  logic          cnt_first;
  logic          cnt_last;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [KW-1:0] k;

  logic          valid_q;
  logic          first_q;
  logic          last_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;

  logic [31:0]             a_full;
  logic [31:0]             b_full;
  logic [DATA_WIDTH_A-1:0] a_word;
  logic [DATA_WIDTH_B-1:0] b_word;

  linproj_tile_counter #(
    .ROWS  (ROW_BLOCKS),
    .COLS  (COL_BLOCKS),
    .INNER (INNER_BLOCKS),
    .RW    (RW),
    .CW    (CW),
    .KW    (KW)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .en_i    (issue),
    .r_o     (r),
    .c_o     (c),
    .k_o     (k),
    .first_o (cnt_first),
    .last_o  (cnt_last),
    .end_o   (cnt_end)
  );

  assign adv   = !valid_q || bus.out_ready;
  assign issue = (state_q == READ) && adv;

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = READ;
          cnt_clr = 1'b1;
        end
      end
      READ: begin
        if (issue && cnt_end) state_d = DRAIN;
      end
      DRAIN: begin
        if (valid_q && bus.out_ready) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Markers travel with the read so they line up with BRAM data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else if (issue) begin
      valid_q <= 1'b1;
      first_q <= cnt_first;
      last_q  <= cnt_last;
      row_q   <= r;
      col_q   <= c;
    end else if (adv) begin
      valid_q <= 1'b0;
    end
  end

  assign a_full = 32'(r) * 32'(INNER_BLOCKS) + 32'(k);
  assign b_full = 32'(c) * 32'(INNER_BLOCKS) + 32'(k);

  assign bus.a_en   = issue;
  assign bus.b_en   = issue;
  assign bus.a_addr = ADDR_WIDTH_A'(a_full);
  assign bus.b_addr = ADDR_WIDTH_B'(b_full);

  assign a_word = bus.a_dout;
  assign b_word = bus.b_dout;

  assign bus.out_valid   = valid_q;
  assign bus.out_a       = valid_q ? a_word : '0;
  assign bus.out_b       = valid_q ? b_word : '0;
  assign bus.out_first   = first_q;
  assign bus.out_last    = last_q;
  assign bus.out_row_idx = row_q;
  assign bus.out_col_idx = col_q;

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);

  a_addr_fits: assert property (
    @(posedge clk) disable iff (rst)
    issue |-> ((a_full >> ADDR_WIDTH_A) == 32'd0)
  );

  b_addr_fits: assert property (
    @(posedge clk) disable iff (rst)
    issue |-> ((b_full >> ADDR_WIDTH_B) == 32'd0)
  );

endmodule

// File: doc/linproj_bram_reader.md
Name: linproj_bram_reader

Overview:
- Read-sequencing controller between the input-matrix and weight-matrix true-dual-port BRAMs and the multi-matmul wrapper in the linear-projection path.
- On a start pulse, walks both BRAMs in tiled order: output-tile row, then output-tile column, then inner-dimension block.
- Issues read enables and addresses, and aligns the 1-cycle BRAM read data.
- Presents matched A/B word pairs to the multiplier with valid/ready flow control and first/last tile markers for accumulation.

Parameters:
- ROW_BLOCKS, 2: output-tile rows; A_OUTER_DIMENSION/(BLOCK_SIZE*NUM_CORES_A*TOTAL_INPUT_W) at integration.
- COL_BLOCKS, 2: output-tile columns; B_OUTER_DIMENSION/(BLOCK_SIZE*NUM_CORES_B*TOTAL_MODULES) at integration.
- INNER_BLOCKS, 3: BRAM words per tile along the inner dimension.
- ADDR_WIDTH_A, 16: input-matrix BRAM address width.
- ADDR_WIDTH_B, 16: weight BRAM address width.
- DATA_WIDTH_A, 64: input-matrix BRAM word width (WIDTH_A*CHUNK_SIZE*NUM_CORES_A).
- DATA_WIDTH_B, 64: weight BRAM word width (WIDTH_B*CHUNK_SIZE*NUM_CORES_B).

Ports:
- clk, in, 1: single clock for all logic.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: single-cycle pulse; begins a full matrix pass; ignored while busy.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse after the final beat is accepted.
- a_en, out, 1: input-matrix BRAM read enable (port B).
- a_addr, out, ADDR_WIDTH_A: input-matrix BRAM read address.
- a_dout, in, DATA_WIDTH_A: input-matrix BRAM read data; READ_LATENCY 1; holds while a_en is low.
- b_en, out, 1: weight BRAM read enable.
- b_addr, out, ADDR_WIDTH_B: weight BRAM read address.
- b_dout, in, DATA_WIDTH_B: weight BRAM read data; READ_LATENCY 1.
- out_valid, out, 1: out_a/out_b hold a valid pair.
- out_ready, in, 1: downstream accepts the pair when out_valid && out_ready.
- out_a, out, DATA_WIDTH_A: equals a_dout.
- out_b, out, DATA_WIDTH_B: equals b_dout.
- out_first, out, 1: beat is inner index k==0 of its tile (clear accumulator).
- out_last, out, 1: beat is k==INNER_BLOCKS-1 (tile result complete).
- out_row_idx, out, $clog2(ROW_BLOCKS)+1: tile row of the current beat.
- out_col_idx, out, $clog2(COL_BLOCKS)+1: tile column of the current beat.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters r/c/k = 0.
- FSM states and transitions:
  - IDLE: start -> READ; clear r, c, k.
  - READ: issue reads; after the last address (r,c,k all at max) has been issued -> DRAIN.
  - DRAIN: wait until the final beat is accepted -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Advance condition: adv = !out_valid || out_ready.
- In READ, a_en = b_en = adv. Addresses are combinational from the counters:
  - a_addr = r*INNER_BLOCKS + k
  - b_addr = c*INNER_BLOCKS + k
- On a read issue (en && adv): out_valid is 1 next cycle; out_first, out_last, out_row_idx and out_col_idx are registered alongside so they align with the data.
- When en=0, the BRAM holds its dout, so a stalled pair stays stable. out_valid, out_a, out_b and the markers must not change while out_valid && !out_ready.
- If adv is true and no read was issued (DRAIN/IDLE), out_valid clears next cycle.
- Counter order: k increments; on wrap, k=0 and c increments; on c wrap, c=0 and r increments.
- Address arithmetic is computed at full width and truncated to ADDR_WIDTH. Overflow is a configuration error and is flagged by an assertion in simulation.
- Throughput: one pair per cycle when out_ready is held high.
- Latency: start at cycle T gives first a_en at T+1 and first out_valid at T+2. done pulses on the cycle after the last handshake.
- start while busy: ignored, no restart.
- start and rst in the same cycle: rst wins.
- rst mid-pass: return to IDLE immediately next cycle. out_valid drops to 0, no done pulse, counters cleared.
- out_ready low throughout: the first pair is held indefinitely and no further addresses are issued.
- Degenerate INNER_BLOCKS=1: out_first and out_last are both 1 on every beat.

Decomposition:
- linear_proj_pkg holds:
  - the state enum typedef (IDLE, READ, DRAIN, DONE);
  - derived constants ROW_BLOCKS/COL_BLOCKS/INNER_BLOCKS computed from the existing dimension parameters, so the top level passes them through.
- One natural sub-module: linproj_tile_counter, a nested r/c/k counter with an enable input that outputs indices, first/last flags and an end-of-pass flag.
- Address generation and valid alignment stay in the parent.

Test Plan:
- Default params, out_ready=1, start pulse:
  - a_addr sequence 0,1,2,0,1,2,3,4,5,3,4,5;
  - b_addr sequence 0,1,2,3,4,5,0,1,2,3,4,5;
  - 12 consecutive out_valid beats;
  - out_first on beats 0,3,6,9; out_last on beats 2,5,8,11;
  - done exactly one cycle after beat 11.
- BRAMs preloaded with word=address; out_ready toggling 1,0,0,1 repeating:
  - out_a/out_b match the expected address pairs in order;
  - no beat lost or duplicated;
  - data stable throughout each stall.
- start asserted at beat 5 while busy: sequence unaffected, single done pulse.
- rst asserted at beat 7:
  - next cycle out_valid=0, busy=0, a_en=0, no done pulse;
  - a new start replays from a_addr=0, b_addr=0.
- INNER_BLOCKS=1, ROW_BLOCKS=1, COL_BLOCKS=3: b_addr 0,1,2; a_addr 0,0,0; out_first=out_last=1 on all 3 beats.
- out_ready held 0 for 20 cycles after the first valid: exactly one read issued; a_en low for the whole stall.
